// File: rtl/blokus_stream_pkg.sv
// Shared widths and FIFO entry layout for the Blokus host<->core stream bridge.
// An entry is {eos, data}: the EOS tag sits at bit index DATA_W.
package blokus_stream_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned IN_AW_DEF  = 4;
  localparam int unsigned OUT_AW_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef struct packed {
    logic                  eos;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

  function automatic int unsigned entry_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO with AW+1 bit wrapping pointers.
// The head word is read combinationally from storage at the read pointer.
module stream_fifo #(
  parameter int unsigned W  = 9,
  parameter int unsigned AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Push is refused when full at edge start; pop is refused when empty (no bypass).
  assign wr_ok = push & ~full;
  assign rd_ok = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/blokus_stream_bridge.sv
// Host<->core stream bridge: input and output FWFT FIFOs of {eos,data} entries,
// frame counters on EOS transfers and sticky overflow/underflow flags.
module blokus_stream_bridge
  import blokus_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IN_AW  = IN_AW_DEF,
  parameter int unsigned OUT_AW = OUT_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              eos_in,
  output logic              in_full,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              eos_out,
  output logic              out_empty,
  output logic              prod_en,
  output logic [DATA_W-1:0] prod_data,
  output logic              prod_eos,
  input  logic              prod_rdy,
  output logic              cons_en,
  input  logic [DATA_W-1:0] cons_data,
  input  logic              cons_eos,
  input  logic              cons_rdy,
  output logic [CNT_W-1:0]  in_frames,
  output logic [CNT_W-1:0]  out_frames,
  output logic              ovf_err,
  output logic              udf_err,
  input  logic              clear_err
);

  localparam int unsigned ENTRY_W = entry_w(DATA_W);

  logic [ENTRY_W-1:0] in_head;
  logic [ENTRY_W-1:0] out_head;
  logic               in_empty;
  logic               out_full;
  logic               in_push;
  logic               in_pop;
  logic               out_push;
  logic               out_pop;

  assign in_push  = wr & ~in_full;
  assign in_pop   = prod_en & prod_rdy;
  assign out_push = cons_rdy & cons_en;
  assign out_pop  = rd & ~out_empty;

  stream_fifo #(.W(ENTRY_W), .AW(IN_AW)) u_in_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (in_push),
    .wdata ({eos_in, data_in}),
    .pop   (in_pop),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  stream_fifo #(.W(ENTRY_W), .AW(OUT_AW)) u_out_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (out_push),
    .wdata ({cons_eos, cons_data}),
    .pop   (out_pop),
    .rdata (out_head),
    .full  (out_full),
    .empty (out_empty)
  );

  // Head words are masked while empty so unwritten storage never leaks out after reset.
  assign prod_en   = ~in_empty;
  assign prod_data = in_empty ? '0 : in_head[DATA_W-1:0];
  assign prod_eos  = ~in_empty & in_head[DATA_W];
  assign cons_en   = ~out_full;
  assign data_out  = out_empty ? '0 : out_head[DATA_W-1:0];
  assign eos_out   = ~out_empty & out_head[DATA_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_frames  <= '0;
      out_frames <= '0;
    end else begin
      if (in_push & eos_in)             in_frames  <= in_frames + CNT_W'(1);
      if (out_pop & out_head[DATA_W])   out_frames <= out_frames + CNT_W'(1);
    end
  end

  // Sticky flags: a new error event in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr & in_full)        ovf_err <= 1'b1;
      else if (clear_err)      ovf_err <= 1'b0;
      if (rd & out_empty)      udf_err <= 1'b1;
      else if (clear_err)      udf_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blokus_stream_bridge.sv
// Scoreboard bench for blokus_stream_bridge: queue-based reference of both FIFOs,
// counters and flags, checked every falling edge against the DUT.
module tb_blokus_stream_bridge;
  import blokus_stream_pkg::*;

  localparam int IN_D  = 16;
  localparam int OUT_D = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr, eos_in, rd, clear_err;
  logic [7:0]  data_in;
  logic        in_full, eos_out, out_empty, prod_en, prod_eos, cons_en;
  logic [7:0]  data_out, prod_data;
  logic [15:0] in_frames, out_frames;
  logic        ovf_err, udf_err;

  // Core emulation: loopback from producer to consumer side, or direct drive.
  logic        loop, lb_go, prod_rdy_d, cons_rdy_d, cons_eos_d;
  logic [7:0]  cons_data_d;
  logic        prod_rdy, cons_rdy, cons_eos;
  logic [7:0]  cons_data;

  assign prod_rdy  = loop ? (lb_go & cons_en) : prod_rdy_d;
  assign cons_rdy  = loop ? (prod_en & lb_go & cons_en) : cons_rdy_d;
  assign cons_data = loop ? prod_data : cons_data_d;
  assign cons_eos  = loop ? prod_eos : cons_eos_d;

  always #5 clk = ~clk;

  blokus_stream_bridge dut (
    .clk(clk), .reset(reset), .wr(wr), .data_in(data_in), .eos_in(eos_in),
    .in_full(in_full), .rd(rd), .data_out(data_out), .eos_out(eos_out),
    .out_empty(out_empty), .prod_en(prod_en), .prod_data(prod_data),
    .prod_eos(prod_eos), .prod_rdy(prod_rdy), .cons_en(cons_en),
    .cons_data(cons_data), .cons_eos(cons_eos), .cons_rdy(cons_rdy),
    .in_frames(in_frames), .out_frames(out_frames), .ovf_err(ovf_err),
    .udf_err(udf_err), .clear_err(clear_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  entry_t      in_q[$];
  entry_t      out_q[$];
  logic [15:0] m_inf, m_outf;
  logic        m_ovf, m_udf;

  always @(negedge clk) begin
    if (!reset) begin
      in_q.delete(); out_q.delete();
      m_inf = '0; m_outf = '0; m_ovf = 1'b0; m_udf = 1'b0;
      chk("rst_out_empty", out_empty, 1);
      chk("rst_in_full", in_full, 0);
      chk("rst_prod_en", prod_en, 0);
      chk("rst_cons_en", cons_en, 1);
      chk("rst_data_out", {eos_out, data_out}, 0);
      chk("rst_frames", {in_frames, out_frames}, 0);
      chk("rst_errs", {ovf_err, udf_err}, 0);
    end else begin
      bit     in_pop, in_push, out_pop, out_push, in_was_full, out_was_empty;
      entry_t moved, e;
      chk("in_full", in_full, in_q.size() == IN_D);
      chk("prod_en", prod_en, in_q.size() != 0);
      if (in_q.size() != 0) chk("prod_head", {prod_eos, prod_data}, in_q[0]);
      chk("out_empty", out_empty, out_q.size() == 0);
      chk("cons_en", cons_en, out_q.size() < OUT_D);
      if (out_q.size() != 0) chk("host_head", {eos_out, data_out}, out_q[0]);
      chk("in_frames", in_frames, m_inf);
      chk("out_frames", out_frames, m_outf);
      chk("ovf_err", ovf_err, m_ovf);
      chk("udf_err", udf_err, m_udf);
      // Predict the coming edge from the inputs now applied
      in_was_full   = (in_q.size() == IN_D);
      out_was_empty = (out_q.size() == 0);
      in_pop   = (in_q.size() != 0) && (loop ? (lb_go && out_q.size() < OUT_D) : prod_rdy_d);
      out_push = loop ? in_pop : (cons_rdy_d && out_q.size() < OUT_D);
      out_pop  = rd && !out_was_empty;
      in_push  = wr && !in_was_full;
      moved = '0;
      if (in_pop) moved = in_q.pop_front();
      if (out_pop) begin
        e = out_q.pop_front();
        if (e.eos) m_outf = m_outf + 16'd1;
      end
      if (out_push) begin
        if (loop) out_q.push_back(moved);
        else begin
          e.eos = cons_eos_d; e.data = cons_data_d;
          out_q.push_back(e);
        end
      end
      if (in_push) begin
        e.eos = eos_in; e.data = data_in;
        in_q.push_back(e);
        if (eos_in) m_inf = m_inf + 16'd1;
      end
      if (wr && in_was_full) m_ovf = 1'b1;
      else if (clear_err)    m_ovf = 1'b0;
      if (rd && out_was_empty) m_udf = 1'b1;
      else if (clear_err)      m_udf = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; wr = 0; eos_in = 0; rd = 0; clear_err = 0; data_in = '0;
    loop = 0; lb_go = 0; prod_rdy_d = 0; cons_rdy_d = 0; cons_eos_d = 0; cons_data_d = '0;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Pass-through with core loopback
    loop = 1; lb_go = 1;
    wr = 1; data_in = 8'h11; step();
    data_in = 8'h22; step();
    data_in = 8'h33; eos_in = 1; step();
    wr = 0; eos_in = 0;
    repeat (6) step();
    chk("pt_head", {eos_out, data_out}, 9'h011);
    rd = 1; repeat (3) step(); rd = 0;
    step();
    chk("pt_in_frames", in_frames, 1);
    chk("pt_out_frames", out_frames, 1);
    chk("pt_drained", out_empty, 1);

    // Input full and overflow
    loop = 0; prod_rdy_d = 0; cons_rdy_d = 0;
    for (int i = 1; i <= 17; i++) begin
      wr = 1; data_in = 8'($urandom); eos_in = (i == 16);
      step();
      if (i == 16) begin
        chk("full_after16", in_full, 1);
        chk("no_ovf_at16", ovf_err, 0);
      end
    end
    wr = 0; eos_in = 0;
    chk("ovf_after17", ovf_err, 1);
    prod_rdy_d = 1; n = 0;
    repeat (20) begin
      if (prod_en) n++;
      step();
    end
    prod_rdy_d = 0;
    chk("drain_count", n, 16);
    clear_err = 1; step(); clear_err = 0;
    chk("ovf_cleared", ovf_err, 0);

    // Output backpressure
    cons_rdy_d = 1;
    repeat (16) begin
      cons_data_d = 8'($urandom); cons_eos_d = 1'($urandom);
      step();
    end
    chk("out_full_cons_en", cons_en, 0);
    cons_data_d = 8'($urandom); step();
    cons_rdy_d = 0; rd = 1; step(); rd = 0;
    chk("cons_en_after_pop", cons_en, 1);
    rd = 1; repeat (15) step(); rd = 0;
    chk("out_drained", out_empty, 1);

    // Underflow and clear
    rd = 1; step(); rd = 0;
    chk("udf_set", udf_err, 1);
    chk("udf_frames", out_frames, m_outf);
    clear_err = 1; step(); clear_err = 0;
    chk("udf_cleared", udf_err, 0);
    rd = 1; clear_err = 1; step(); rd = 0; clear_err = 0;
    chk("udf_set_wins", udf_err, 1);
    clear_err = 1; step(); clear_err = 0;

    // Random traffic with pointer wrap, async reset mid-burst
    loop = 1;
    repeat (150) begin
      wr = 1'($urandom_range(0, 1)); data_in = 8'($urandom);
      eos_in = ($urandom_range(0, 3) == 0); rd = 1'($urandom_range(0, 1));
      lb_go = ($urandom_range(0, 3) != 0); clear_err = ($urandom_range(0, 15) == 0);
      step();
    end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("ar_out_empty", out_empty, 1);
    chk("ar_in_full", in_full, 0);
    chk("ar_prod_en", prod_en, 0);
    chk("ar_cons_en", cons_en, 1);
    chk("ar_data_out", {eos_out, data_out}, 0);
    chk("ar_frames", {in_frames, out_frames}, 0);
    chk("ar_errs", {ovf_err, udf_err}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (80) begin
      wr = 1'($urandom_range(0, 1)); data_in = 8'($urandom);
      eos_in = ($urandom_range(0, 3) == 0); rd = 1'($urandom_range(0, 1));
      lb_go = ($urandom_range(0, 3) != 0); clear_err = 0;
      step();
    end
    wr = 0; lb_go = 1; rd = 1;
    repeat (40) step();
    rd = 0;
    chk("final_out_empty", out_empty, 1);
    chk("final_prod_en", prod_en, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
